// File: rtl/uart_rx_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_ctrl_if
// Bundles the receiver-side strobes, the payload stream and the packet
// verdict of uart_rx_frame_ctrl into one interface.
//
// Signals
//   tick      baud oversampling tick, one clock wide
//   rx_ready  one-cycle strobe: rx_data holds a new byte
//   rx_data   received byte
//   out_valid payload FIFO head valid
//   out_data  payload FIFO head byte (0 when FIFO empty)
//   out_last  head byte is the final payload byte of its frame
//   out_ready consumer accepts the head when out_valid && out_ready
//   pkt_ok    one-cycle pulse: frame complete, checksum good
//   pkt_err   one-cycle pulse: frame aborted or bad
//   err_code  0=checksum 1=length 2=timeout 3=overflow, held until next pkt_err
//   busy      parser is inside a frame
//
// Modports
//   slave  : the frame controller (consumes rx/tick/out_ready)
//   master : the environment (UART receiver + payload consumer)
// ---------------------------------------------------------------------------
interface uart_rx_frame_ctrl_if;
    logic       tick;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       pkt_ok;
    logic       pkt_err;
    logic [1:0] err_code;
    logic       busy;

    modport slave (
        input  tick, rx_ready, rx_data, out_ready,
        output out_valid, out_data, out_last, pkt_ok, pkt_err, err_code, busy
    );

    modport master (
        output tick, rx_ready, rx_data, out_ready,
        input  out_valid, out_data, out_last, pkt_ok, pkt_err, err_code, busy
    );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_ctrl
// Packet-level sequencer downstream of a UART receiver. Parses frames of the
// form SYNC, LEN, LEN payload bytes, CSUM (CSUM = LEN + payload, mod 256),
// streams the payload through a small FIFO with valid/ready handshake and
// reports a registered per-packet verdict. Inter-byte gaps inside a frame are
// supervised by counting baud ticks.
//
// Ports
//   clk    system clock
//   rst_n  asynchronous active-low reset; a mid-frame reset discards the
//          frame silently
//   bus    uart_rx_frame_ctrl_if.slave (see the interface file for signals)
// ---------------------------------------------------------------------------
module uart_rx_frame_ctrl #(
    parameter logic [7:0] SYNC_BYTE     = 8'hA5,
    parameter int         MAX_LEN       = 16,
    parameter int         TIMEOUT_TICKS = 512,
    parameter int         FIFO_DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    uart_rx_frame_ctrl_if.slave    bus
);

    localparam int TMO_W = $clog2(TIMEOUT_TICKS);
    localparam int AW    = $clog2(FIFO_DEPTH);

    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
    // The counter never has to hold TIMEOUT_TICKS itself: the tick that would
    // reach it fires the timeout instead.
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_TICKS - 1);

    localparam logic [1:0] ERR_CSUM = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_TMO  = 2'd2;
    localparam logic [1:0] ERR_OVF  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       remaining_q, remaining_d;
    logic [7:0]       sum_q, sum_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             pkt_ok_q, pkt_ok_d;
    logic             pkt_err_q, pkt_err_d;
    logic [1:0]       err_code_q, err_code_d;

    // -----------------------------------------------------------------------
    // Payload FIFO: entries are {last, data}. Pointers carry one extra wrap
    // bit so full and empty are distinguishable.
    // -----------------------------------------------------------------------
    logic [8:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        fifo_empty, fifo_full;
    logic        push, pop;
    logic [8:0]  push_data;
    logic [8:0]  head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop        = !fifo_empty && bus.out_ready;
    assign head       = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Head is gated so the stream reads as zeros while empty (the storage
    // itself is never reset).
    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_empty ? 8'h00 : head[7:0];
    assign bus.out_last  = !fifo_empty && head[8];

    // -----------------------------------------------------------------------
    // Frame parser: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            sum_q       <= '0;
            tmo_q       <= '0;
            pkt_ok_q    <= 1'b0;
            pkt_err_q   <= 1'b0;
            err_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            sum_q       <= sum_d;
            tmo_q       <= tmo_d;
            pkt_ok_q    <= pkt_ok_d;
            pkt_err_q   <= pkt_err_d;
            err_code_q  <= err_code_d;
        end
    end

    // -----------------------------------------------------------------------
    // Frame parser: next state. A byte strobe always takes priority over a
    // tick in the same cycle, so the gap counter restarts instead of timing
    // out.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        sum_d       = sum_q;
        tmo_d       = tmo_q;
        pkt_ok_d    = 1'b0;
        pkt_err_d   = 1'b0;
        err_code_d  = err_code_q;
        push        = 1'b0;
        push_data   = 9'h000;

        case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (bus.rx_ready && bus.rx_data == SYNC_BYTE) begin
                    state_d = ST_LEN;
                end
            end

            ST_LEN: begin
                if (bus.rx_ready) begin
                    tmo_d = '0;
                    if (bus.rx_data >= 8'd1 && bus.rx_data <= MAX_LEN_B) begin
                        state_d     = ST_PAYLOAD;
                        remaining_d = bus.rx_data;
                        sum_d       = bus.rx_data;
                    end else begin
                        pkt_err_d  = 1'b1;
                        err_code_d = ERR_LEN;
                        state_d    = ST_IDLE;
                    end
                end else if (bus.tick) begin
                    if (tmo_q == TMO_LAST) begin
                        pkt_err_d  = 1'b1;
                        err_code_d = ERR_TMO;
                        state_d    = ST_IDLE;
                        tmo_d      = '0;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end

            ST_PAYLOAD: begin
                if (bus.rx_ready) begin
                    tmo_d = '0;
                    // A full FIFO still takes the byte if the head leaves
                    // in the same cycle.
                    if (fifo_full && !pop) begin
                        pkt_err_d  = 1'b1;
                        err_code_d = ERR_OVF;
                        state_d    = ST_IDLE;
                    end else begin
                        push        = 1'b1;
                        push_data   = {remaining_q == 8'd1, bus.rx_data};
                        sum_d       = sum_q + bus.rx_data;
                        remaining_d = remaining_q - 8'd1;
                        if (remaining_q == 8'd1) begin
                            state_d = ST_CSUM;
                        end
                    end
                end else if (bus.tick) begin
                    if (tmo_q == TMO_LAST) begin
                        pkt_err_d  = 1'b1;
                        err_code_d = ERR_TMO;
                        state_d    = ST_IDLE;
                        tmo_d      = '0;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end

            ST_CSUM: begin
                if (bus.rx_ready) begin
                    tmo_d   = '0;
                    state_d = ST_IDLE;
                    if (bus.rx_data == sum_q) begin
                        pkt_ok_d = 1'b1;
                    end else begin
                        pkt_err_d  = 1'b1;
                        err_code_d = ERR_CSUM;
                    end
                end else if (bus.tick) begin
                    if (tmo_q == TMO_LAST) begin
                        pkt_err_d  = 1'b1;
                        err_code_d = ERR_TMO;
                        state_d    = ST_IDLE;
                        tmo_d      = '0;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.pkt_ok   = pkt_ok_q;
    assign bus.pkt_err  = pkt_err_q;
    assign bus.err_code = err_code_q;
    assign bus.busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_frame_ctrl
// Self-checking bench for uart_rx_frame_ctrl. Expected payload entries
// ({last, data}) and expected verdicts ({is_err, code}) are queued as the
// stimulus is driven and compared when the DUT hands them out.
// ---------------------------------------------------------------------------
module tb_uart_rx_frame_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    uart_rx_frame_ctrl_if bus_if();

    uart_rx_frame_ctrl #(
        .SYNC_BYTE     (8'hA5),
        .MAX_LEN       (16),
        .TIMEOUT_TICKS (512),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int n_cmp = 0;
    int n_mis = 0;

    logic [8:0] pay_q[$];   // {last, data}
    logic [2:0] ver_q[$];   // {is_err, err_code}; 3'b000 = PktOk

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_if.out_valid && bus_if.out_ready) begin
                if (pay_q.size() == 0) begin
                    check_val("pay_unexpected", 32'(pay_q.size()), 32'd1);
                end else begin
                    logic [8:0] e;
                    e = pay_q.pop_front();
                    $display("rx payload data=%02h last=%0b (exp %02h/%0b)",
                             bus_if.out_data, bus_if.out_last, e[7:0], e[8]);
                    check_val("pay", {23'd0, bus_if.out_last, bus_if.out_data}, {23'd0, e});
                end
            end
            if (bus_if.pkt_ok || bus_if.pkt_err) begin
                check_val("ok_err_excl", 32'(bus_if.pkt_ok && bus_if.pkt_err), 32'd0);
                if (ver_q.size() == 0) begin
                    check_val("verdict_unexpected", 32'(ver_q.size()), 32'd1);
                end else begin
                    logic [2:0] v;
                    logic [2:0] g;
                    v = ver_q.pop_front();
                    g = bus_if.pkt_err ? {1'b1, bus_if.err_code} : 3'b000;
                    $display("rx verdict ok=%0b err=%0b code=%0d (exp %03b)",
                             bus_if.pkt_ok, bus_if.pkt_err, bus_if.err_code, v);
                    check_val("verdict", {29'd0, g}, {29'd0, v});
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Returns 1 time unit after the edge that sampled the strobe.
    task automatic send_byte(input logic [7:0] b, input logic with_tick);
        @(posedge clk); #1;
        bus_if.rx_ready = 1'b1;
        bus_if.rx_data  = b;
        bus_if.tick     = with_tick;
        @(posedge clk); #1;
        bus_if.rx_ready = 1'b0;
        bus_if.tick     = 1'b0;
        $display("tx byte %02h tick=%0b", b, with_tick);
    endtask

    task automatic send_pay(input logic [7:0] b, input logic last);
        pay_q.push_back({last, b});
        send_byte(b, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus_if.tick = 1'b1;
            @(posedge clk); #1;
            bus_if.tick = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (pay_q.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        check_val("drain_timeout", 32'(pay_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        bus_if.tick      = 1'b0;
        bus_if.rx_ready  = 1'b0;
        bus_if.rx_data   = 8'h00;
        bus_if.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_valid", 32'(bus_if.out_valid), 32'd0);
        check_val("rst_data",  32'(bus_if.out_data),  32'd0);
        check_val("rst_last",  32'(bus_if.out_last),  32'd0);
        check_val("rst_ok",    32'(bus_if.pkt_ok),    32'd0);
        check_val("rst_err",   32'(bus_if.pkt_err),   32'd0);
        check_val("rst_code",  32'(bus_if.err_code),  32'd0);
        check_val("rst_busy",  32'(bus_if.busy),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1. good frame A5 03 11 22 33 69
        send_byte(8'hA5, 1'b0);
        check_val("t1_busy_after_sync", 32'(bus_if.busy), 32'd1);
        send_byte(8'h03, 1'b0);
        send_pay(8'h11, 1'b0);
        check_val("t1_latency_valid", 32'(bus_if.out_valid), 32'd1);
        check_val("t1_latency_data",  32'(bus_if.out_data),  32'h11);
        send_pay(8'h22, 1'b0);
        send_pay(8'h33, 1'b1);
        ver_q.push_back(3'b000);
        send_byte(8'h69, 1'b0);
        check_val("t1_ok_pulse", 32'(bus_if.pkt_ok), 32'd1);
        @(posedge clk); #1;
        check_val("t1_ok_width", 32'(bus_if.pkt_ok), 32'd0);
        check_val("t1_busy_idle", 32'(bus_if.busy), 32'd0);
        wait_drain();

        // 2. bad checksum 68
        send_byte(8'hA5, 1'b0);
        send_byte(8'h03, 1'b0);
        send_pay(8'h11, 1'b0);
        send_pay(8'h22, 1'b0);
        send_pay(8'h33, 1'b1);
        ver_q.push_back(3'b100);
        send_byte(8'h68, 1'b0);
        check_val("t2_err_pulse", 32'(bus_if.pkt_err), 32'd1);
        check_val("t2_code",      32'(bus_if.err_code), 32'd0);
        check_val("t2_no_ok",     32'(bus_if.pkt_ok),  32'd0);
        wait_drain();

        // 3. LEN 0 and LEN 17, then a good frame
        send_byte(8'hA5, 1'b0);
        ver_q.push_back(3'b101);
        send_byte(8'h00, 1'b0);
        check_val("t3_len0_err",  32'(bus_if.pkt_err),  32'd1);
        check_val("t3_len0_code", 32'(bus_if.err_code), 32'd1);
        send_byte(8'hA5, 1'b0);
        ver_q.push_back(3'b101);
        send_byte(8'h11, 1'b0);
        check_val("t3_len17_err",  32'(bus_if.pkt_err),  32'd1);
        check_val("t3_len17_code", 32'(bus_if.err_code), 32'd1);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h10, 1'b0);   // LEN 16 = MAX_LEN, accepted
        for (int i = 0; i < 16; i++) begin
            send_pay(8'(i + 1), i == 15);
        end
        ver_q.push_back(3'b000);
        send_byte(8'h98, 1'b0);   // 0x10 + sum(1..16)=0x88 -> 0x98
        check_val("t3_max_ok", 32'(bus_if.pkt_ok), 32'd1);
        wait_drain();

        // 4. timeout after A5 04 AA BB; ticks coinciding with bytes are ignored
        send_byte(8'hA5, 1'b1);
        send_byte(8'h04, 1'b1);
        pay_q.push_back(9'h0AA);
        send_byte(8'hAA, 1'b1);
        ticks(100);
        pay_q.push_back(9'h0BB);
        send_byte(8'hBB, 1'b1);
        ticks(511);
        check_val("t4_no_early", 32'(bus_if.pkt_err), 32'd0);
        check_val("t4_busy",     32'(bus_if.busy),    32'd1);
        ver_q.push_back(3'b110);
        ticks(1);
        check_val("t4_tmo_err",  32'(bus_if.pkt_err),  32'd1);
        check_val("t4_tmo_code", 32'(bus_if.err_code), 32'd2);
        @(posedge clk); #1;
        check_val("t4_busy_idle", 32'(bus_if.busy), 32'd0);
        wait_drain();

        // 5. overflow with OutReady low
        bus_if.out_ready = 1'b0;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h06, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            send_pay(8'(i), 1'b0);
        end
        ver_q.push_back(3'b111);
        send_byte(8'h05, 1'b0);
        check_val("t5_ovf_err",  32'(bus_if.pkt_err),  32'd1);
        check_val("t5_ovf_code", 32'(bus_if.err_code), 32'd3);
        check_val("t5_head",     32'(bus_if.out_data), 32'h01);
        repeat (3) @(posedge clk);
        #1;
        check_val("t5_stable_valid", 32'(bus_if.out_valid), 32'd1);
        check_val("t5_stable_data",  32'(bus_if.out_data),  32'h01);
        bus_if.out_ready = 1'b1;
        wait_drain();
        check_val("t5_empty_valid", 32'(bus_if.out_valid), 32'd0);
        check_val("t5_empty_data",  32'(bus_if.out_data),  32'd0);

        // 6. reset mid-payload
        bus_if.out_ready = 1'b0;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h20, 1'b0);
        check_val("t6_pre_valid", 32'(bus_if.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t6_rst_valid", 32'(bus_if.out_valid), 32'd0);
        check_val("t6_rst_data",  32'(bus_if.out_data),  32'd0);
        check_val("t6_rst_busy",  32'(bus_if.busy),      32'd0);
        check_val("t6_rst_err",   32'(bus_if.pkt_err),   32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus_if.out_ready = 1'b1;
        send_byte(8'h12, 1'b0);
        check_val("t6_stray_busy1", 32'(bus_if.busy), 32'd0);
        send_byte(8'h34, 1'b0);
        check_val("t6_stray_busy2", 32'(bus_if.busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_val("t6_post_valid", 32'(bus_if.out_valid), 32'd0);

        // Leftover expectations mean missing outputs
        check_val("pay_left",     32'(pay_q.size()), 32'd0);
        check_val("verdict_left", 32'(ver_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
